// File: rtl/rf2_1r1w_wm_model.sv
// Behavioural model of a two-port (port A read, port B write) register-file macro with a
// per-bit write mask. Single clock. Adds registered checker pulses for misuse: collision,
// uninitialised read, out-of-range address and test-enable errors.
module rf2_1r1w_wm_model #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIDTH  = 68
) (
    input  logic              clock,
    input  logic              reset,
    // Port A: read
    input  logic [ADDR_W-1:0] AA,
    input  logic              CENA,
    output logic [WIDTH-1:0]  QA,
    // Port B: bit-masked write
    input  logic [ADDR_W-1:0] AB,
    input  logic              CENB,
    input  logic [WIDTH-1:0]  DB,
    input  logic [WIDTH-1:0]  WENB,
    // Functional control pins
    input  logic              COLLDISN,
    input  logic              DFTRAMBYP,
    input  logic              RET1N,
    // Timing margins and scan/test pins, functionally ignored
    input  logic [2:0]        EMAA,
    input  logic [2:0]        EMAB,
    input  logic              EMASA,
    input  logic              SEA,
    input  logic              SEB,
    input  logic [1:0]        SIA,
    input  logic [1:0]        SIB,
    input  logic              TCENA,
    input  logic              TCENB,
    input  logic [ADDR_W-1:0] TAA,
    input  logic [ADDR_W-1:0] TAB,
    input  logic [WIDTH-1:0]  TDB,
    input  logic [WIDTH-1:0]  TWENB,
    input  logic              TENA,
    input  logic              TENB,
    // Checker pulses
    output logic              coll,
    output logic              uninit_rd,
    output logic              addr_err,
    output logic              test_err
);

    // One extra bit so the range compare stays meaningful when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] qa_q, qa_d;
    logic             coll_q, coll_d;
    logic             uninit_q, uninit_d;
    logic             addr_err_q, addr_err_d;
    logic             test_err_q, test_err_d;

    logic aa_ok, ab_ok, active, mask_any, rd_req, rd_arr, wr_en;

    logic unused_pins;
    assign unused_pins = ^{EMAA, EMAB, EMASA, SEA, SEB, SIA, SIB, TCENA, TCENB,
                           TAA, TAB, TDB, TWENB};

    // Decode enables, collision and misuse conditions for this edge.
    always_comb begin
        aa_ok      = {1'b0, AA} < DepthLim;
        ab_ok      = {1'b0, AB} < DepthLim;
        active     = RET1N && !DFTRAMBYP;
        mask_any   = ~&WENB;
        rd_req     = !CENA && RET1N;
        rd_arr     = rd_req && !DFTRAMBYP && aa_ok;
        wr_en      = !CENB && active && ab_ok;
        coll_d     = rd_arr && wr_en && (AA == AB) && mask_any;
        addr_err_d = active && ((!CENA && !aa_ok) || (!CENB && !ab_ok));
        uninit_d   = rd_arr && !valid_q[AA];
        test_err_d = RET1N && (!TENA || !TENB) && (!CENA || !CENB);
    end

    // Next read data: bypass, dropped/uninitialised reads load zero, collisions may mask.
    always_comb begin
        qa_d = qa_q;
        if (rd_req) begin
            if (DFTRAMBYP) begin
                qa_d = DB;
            end else if (!aa_ok || !valid_q[AA]) begin
                qa_d = '0;
            end else begin
                qa_d = mem_q[AA];
                // With collision handling disabled, written bits read back as zero.
                if (coll_d && !COLLDISN) begin
                    qa_d = qa_d & WENB;
                end
            end
        end
    end

    // Output register, valid bits and checker pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qa_q       <= '0;
            valid_q    <= '0;
            coll_q     <= 1'b0;
            uninit_q   <= 1'b0;
            addr_err_q <= 1'b0;
            test_err_q <= 1'b0;
        end else begin
            qa_q       <= qa_d;
            coll_q     <= coll_d;
            uninit_q   <= uninit_d;
            addr_err_q <= addr_err_d;
            test_err_q <= test_err_d;
            if (wr_en && mask_any) begin
                valid_q[AB] <= 1'b1;
            end
        end
    end

    // Array write; the array is not cleared by reset, but writes are suppressed during it.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem_q[AB] <= (mem_q[AB] & WENB) | (DB & ~WENB);
        end
    end

    assign QA        = qa_q;
    assign coll      = coll_q;
    assign uninit_rd = uninit_q;
    assign addr_err  = addr_err_q;
    assign test_err  = test_err_q;

endmodule

// File: tb/tb_rf2_1r1w_wm_model.sv
// Directed bench for rf2_1r1w_wm_model built with DEPTH=24 so out-of-range addresses exist.
// A behavioural model tracks array contents and expected outputs; outputs are compared every
// negative clock edge, with literal expectations at key points of each scenario.
module tb_rf2_1r1w_wm_model;

    localparam int unsigned DEPTH  = 24;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned WIDTH  = 68;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] PAT  = {4'h5, {8{8'hA5}}};

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] AA, AB;
    logic              CENA, CENB;
    logic [WIDTH-1:0]  QA, DB, WENB;
    logic              COLLDISN, DFTRAMBYP, RET1N, TENA, TENB;
    logic              coll, uninit_rd, addr_err, test_err;

    int n_chk  = 0;
    int n_fail = 0;

    rf2_1r1w_wm_model #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .WIDTH (WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .AA       (AA),
        .CENA     (CENA),
        .QA       (QA),
        .AB       (AB),
        .CENB     (CENB),
        .DB       (DB),
        .WENB     (WENB),
        .COLLDISN (COLLDISN),
        .DFTRAMBYP(DFTRAMBYP),
        .RET1N    (RET1N),
        .EMAA     (3'd0),
        .EMAB     (3'd0),
        .EMASA    (1'b0),
        .SEA      (1'b0),
        .SEB      (1'b0),
        .SIA      (2'd0),
        .SIB      (2'd0),
        .TCENA    (1'b1),
        .TCENB    (1'b1),
        .TAA      ('0),
        .TAB      ('0),
        .TDB      ('0),
        .TWENB    ('1),
        .TENA     (TENA),
        .TENB     (TENB),
        .coll     (coll),
        .uninit_rd(uninit_rd),
        .addr_err (addr_err),
        .test_err (test_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    logic [WIDTH-1:0] m_mem [32];
    bit               m_valid [32];
    logic [WIDTH-1:0] e_qa;
    logic             e_coll, e_uninit, e_addr, e_test;

    always @(posedge clock or posedge reset) begin
        logic [WIDTH-1:0] old;
        bit rd, wr;
        if (reset) begin
            e_qa = '0; e_coll = 0; e_uninit = 0; e_addr = 0; e_test = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else begin
            e_coll = 0; e_uninit = 0; e_addr = 0; e_test = 0;
            if (RET1N) begin
                e_test = (!TENA || !TENB) && (!CENA || !CENB);
                if (DFTRAMBYP) begin
                    if (!CENA) e_qa = DB;
                end else begin
                    rd = !CENA;
                    wr = !CENB;
                    if (rd && AA >= DEPTH) begin e_addr = 1; e_qa = '0; rd = 0; end
                    if (wr && AB >= DEPTH) begin e_addr = 1; wr = 0; end
                    if (rd) begin
                        old      = m_valid[AA] ? m_mem[AA] : '0;
                        e_uninit = !m_valid[AA];
                        if (wr && AA == AB && WENB != ONES) begin
                            e_coll = 1;
                            if (!COLLDISN)
                                for (int i = 0; i < WIDTH; i++) if (!WENB[i]) old[i] = 1'b0;
                        end
                        e_qa = old;
                    end
                    if (wr) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (!WENB[i]) begin
                                m_mem[AB][i] = DB[i];
                                m_valid[AB]  = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        check("QA", QA, e_qa);
        check("coll", {67'd0, coll}, {67'd0, e_coll});
        check("uninit_rd", {67'd0, uninit_rd}, {67'd0, e_uninit});
        check("addr_err", {67'd0, addr_err}, {67'd0, e_addr});
        check("test_err", {67'd0, test_err}, {67'd0, e_test});
    end

    // ---------------- Stimulus ----------------
    task automatic idle();
        CENA = 1'b1; CENB = 1'b1; AA = '0; AB = '0; DB = '0; WENB = ONES;
        COLLDISN = 1'b1; DFTRAMBYP = 1'b0; RET1N = 1'b1; TENA = 1'b1; TENB = 1'b1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] wen);
        idle(); CENB = 1'b0; AB = a; DB = d; WENB = wen;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        idle(); CENA = 1'b0; AA = a;
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        step(); step();
        check("reset_QA", QA, '0);
        check("reset_flags", {64'd0, coll, uninit_rd, addr_err, test_err}, '0);
        reset = 1'b0;

        // Full write then read
        wr(5'd3, ONES, '0); step();
        rd(5'd3); step();
        check("rd3_all_ones", QA, ONES);
        check("rd3_no_uninit", {67'd0, uninit_rd}, '0);

        // Masked write: only bits 15:8 take the new data
        wr(5'd5, '0, '0); step();
        wr(5'd5, ONES, ~68'h0FF00); step();
        rd(5'd5); step();
        check("masked_write", QA, 68'h0FF00);

        // Collision, read-before-write
        wr(5'd7, PAT, '0); step();
        rd(5'd7); CENB = 1'b0; AB = 5'd7; DB = '0; WENB = '0; COLLDISN = 1'b1; step();
        check("coll_rbw_flag", {67'd0, coll}, 68'd1);
        check("coll_rbw_QA", QA, PAT);
        // Collision with written bits forced to zero
        wr(5'd7, PAT, '0); step();
        rd(5'd7); CENB = 1'b0; AB = 5'd7; DB = '0; WENB = '0; COLLDISN = 1'b0; step();
        check("coll_mask_flag", {67'd0, coll}, 68'd1);
        check("coll_mask_QA", QA, '0);
        rd(5'd7); step();
        check("after_coll_QA", QA, '0);
        check("after_coll_flag", {67'd0, coll}, '0);

        // Uninitialised read pulses for one cycle only
        rd(5'd9); step();
        check("uninit_QA", QA, '0);
        check("uninit_pulse", {67'd0, uninit_rd}, 68'd1);
        idle(); step();
        check("uninit_cleared", {67'd0, uninit_rd}, '0);

        // Retention: accesses ignored and QA holds
        wr(5'd2, 68'h55, '0); step();
        rd(5'd3); step();
        rd(5'd5); RET1N = 1'b0; CENB = 1'b0; AB = 5'd2; DB = ONES; WENB = '0; step();
        check("ret_QA_hold", QA, ONES);
        rd(5'd2); step();
        check("ret_array_kept", QA, 68'h55);

        // RAM bypass: QA follows DB, array untouched
        rd(5'd3); DFTRAMBYP = 1'b1; CENB = 1'b0; AB = 5'd3; DB = 68'h1234; WENB = '0; step();
        check("byp_QA", QA, 68'h1234);
        check("byp_no_coll", {67'd0, coll}, '0);
        rd(5'd3); step();
        check("byp_array_kept", QA, ONES);

        // Out-of-range addresses
        rd(5'd30); step();
        check("oor_rd_flag", {67'd0, addr_err}, 68'd1);
        check("oor_rd_QA", QA, '0);
        wr(5'd25, ONES, '0); step();
        check("oor_wr_flag", {67'd0, addr_err}, 68'd1);
        idle(); step();
        check("oor_cleared", {67'd0, addr_err}, '0);

        // Test-enable misuse; the access still completes
        rd(5'd3); TENA = 1'b0; step();
        check("test_err_flag", {67'd0, test_err}, 68'd1);
        check("test_err_QA", QA, ONES);
        idle(); step();
        check("test_err_cleared", {67'd0, test_err}, '0);

        // Reset asserted mid-write: QA clears at once and the write is lost
        rd(5'd3); CENB = 1'b0; AB = 5'd11; DB = ONES; WENB = '0;
        #3 reset = 1'b1;
        #1 check("rst_mid_QA", QA, '0);
        step();
        reset = 1'b0;
        rd(5'd11); step();
        check("rst_write_lost_QA", QA, '0);
        check("rst_write_lost_uninit", {67'd0, uninit_rd}, 68'd1);
        idle(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
